// File: rtl/mitchell_log_encoder.sv
// Two-stage Mitchell logarithm front end: leading-one index, left-aligned
// fraction and zero flag, with valid/ready handshakes on both sides.
module mitchell_log_encoder #(
  parameter int unsigned WL_X = 32,
  parameter int unsigned WL_M = 31,
  parameter int unsigned WL_K = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [WL_X-1:0] in_x,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [WL_K-1:0] out_k,
  output logic [WL_M-1:0] out_m,
  output logic            out_zero
);

  logic            s1_valid;
  logic [WL_M-1:0] s1_x;
  logic [WL_K-1:0] s1_k;
  logic            s1_zero;

  logic            s1_en;
  logic            s2_en;
  logic            accept;
  logic [WL_K-1:0] lead_k;
  logic [WL_K-1:0] sh_amt;
  logic [WL_M-1:0] m_aligned;

  assign s2_en    = !out_valid || out_ready;
  assign s1_en    = !s1_valid || s2_en;
  assign in_ready = s1_en && !rst;
  assign accept   = in_valid && in_ready;

  // Priority encode: the highest set bit wins since it is visited last.
  always_comb begin
    lead_k = '0;
    for (int i = 0; i < int'(WL_X); i++) begin
      if (in_x[i]) lead_k = WL_K'(i);
    end
  end

  // Only bits below the leading one can reach the fraction, so the top
  // operand bit is never stored in stage 1.
  assign sh_amt    = WL_K'(WL_X - 1) - s1_k;
  assign m_aligned = s1_x << sh_amt;

  // Stage 1: capture operand, leading-one index and zero flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_x     <= '0;
      s1_k     <= '0;
      s1_zero  <= 1'b0;
    end else if (s1_en) begin
      s1_valid <= accept;
      if (accept) begin
        s1_x    <= in_x[WL_M-1:0];
        s1_k    <= lead_k;
        s1_zero <= (in_x == '0);
      end
    end
  end

  // Stage 2: normalising shift; holds while downstream stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_k     <= '0;
      out_m     <= '0;
      out_zero  <= 1'b0;
    end else if (s2_en) begin
      out_valid <= s1_valid;
      out_k     <= s1_k;
      out_m     <= m_aligned;
      out_zero  <= s1_zero;
    end
  end

endmodule

// File: tb/tb_mitchell_log_encoder.sv
// Bench for mitchell_log_encoder: directed vector table, hand sequences for
// backpressure and reset, and randomized traffic against an arithmetic model.
module tb_mitchell_log_encoder;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_x;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_k;
  logic [30:0] out_m;
  logic        out_zero;

  mitchell_log_encoder dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_x     (in_x),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_k    (out_k),
    .out_m    (out_m),
    .out_zero (out_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_q[$];
  logic        stall_prev = 1'b0;
  logic [4:0]  prev_k;
  logic [30:0] prev_m;
  logic        prev_zero;

  typedef struct {
    logic [31:0] x;
    int          k;
    logic [30:0] m;
    logic        zero;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: characteristic by repeated halving, fraction by scaling
  // x up to a 32-bit value and keeping the remainder below 2^31.
  function automatic int ref_k(input logic [31:0] x);
    longint unsigned v;
    int k;
    v = 64'(x);
    k = 0;
    while (v >= 64'd2) begin
      v = v / 64'd2;
      k++;
    end
    return k;
  endfunction

  function automatic logic [30:0] ref_m(input logic [31:0] x);
    longint unsigned p;
    p = 64'(x) * (64'd1 << (31 - ref_k(x)));
    return 31'(p % (64'd1 << 31));
  endfunction

  // One clock cycle: drive, settle, score handshakes, advance.
  task automatic cycle(input logic v, input logic [31:0] x, input logic ordy, output logic acc);
    logic [31:0] ex;
    in_valid  = v;
    in_x      = x;
    out_ready = ordy;
    #1;
    acc = in_valid && in_ready;
    if (acc) exp_q.push_back(x);
    if (out_valid) begin
      if (stall_prev) begin
        chk("stall_k", 64'(out_k), 64'(prev_k));
        chk("stall_m", 64'(out_m), 64'(prev_m));
        chk("stall_zero", 64'(out_zero), 64'(prev_zero));
      end
      if (out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got k=%0d m=0x%0h expected none", out_k, out_m);
        end else begin
          ex = exp_q.pop_front();
          chk("sb_k", 64'(out_k), 64'(ref_k(ex)));
          chk("sb_m", 64'(out_m), 64'(ref_m(ex)));
          chk("sb_zero", 64'(out_zero), 64'(ex == 32'd0));
        end
      end
    end
    stall_prev = out_valid && !out_ready;
    prev_k     = out_k;
    prev_m     = out_m;
    prev_zero  = out_zero;
    @(posedge clk);
    #1;
  endtask

  vec_t        vecs[7];
  logic        acc;
  logic [31:0] pend[$];
  logic [31:0] rx;
  int          accepted;
  int          n;

  initial begin
    vecs[0] = '{32'h0000_0001, 0,  31'h0000_0000, 1'b0};
    vecs[1] = '{32'h8000_0000, 31, 31'h0000_0000, 1'b0};
    vecs[2] = '{32'h0000_0000, 0,  31'h0000_0000, 1'b1};
    vecs[3] = '{32'h0000_0003, 1,  31'h4000_0000, 1'b0};
    vecs[4] = '{32'hC000_0000, 31, 31'h4000_0000, 1'b0};
    vecs[5] = '{32'h00A0_0000, 23, 31'h2000_0000, 1'b0};
    vecs[6] = '{32'h0060_0000, 22, 31'h4000_0000, 1'b0};

    rst = 1'b1; in_valid = 1'b0; in_x = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_in_ready", 64'(in_ready), 64'd0);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_out_k", 64'(out_k), 64'd0);
    chk("reset_out_m", 64'(out_m), 64'd0);
    rst = 1'b0;

    // Directed vectors, 2-cycle latency with out_ready high
    for (int i = 0; i < 7; i++) begin
      cycle(1'b1, vecs[i].x, 1'b1, acc);
      chk("vec_accept", 64'(acc), 64'd1);
      chk("vec_early_valid", 64'(out_valid), 64'd0);
      cycle(1'b0, 32'd0, 1'b1, acc);
      chk("vec_valid", 64'(out_valid), 64'd1);
      chk("vec_k", 64'(out_k), 64'(vecs[i].k));
      chk("vec_m", 64'(out_m), 64'(vecs[i].m));
      chk("vec_zero", 64'(out_zero), 64'(vecs[i].zero));
      cycle(1'b0, 32'd0, 1'b1, acc);
    end

    // Streaming 1..64 back to back
    for (int i = 0; i < 66; i++) begin
      if (i < 64) begin
        in_valid = 1'b1; out_ready = 1'b1; #1;
        chk("stream_in_ready", 64'(in_ready), 64'd1);
        #(-0);
      end
      if (i >= 2) chk("stream_out_valid", 64'(out_valid), 64'd1);
      cycle(i < 64, 32'(i + 1), 1'b1, acc);
    end
    chk("stream_drained", 64'(exp_q.size()), 64'd0);

    // Backpressure: four operands with out_ready low for four cycles
    pend = '{32'h10, 32'h20, 32'h30, 32'h40};
    for (int c = 0; c < 20; c++) begin
      if (c == 2 || c == 3) begin
        in_valid = 1'b1; in_x = pend[0]; out_ready = 1'b0; #1;
        chk("bp_in_ready_low", 64'(in_ready), 64'd0);
        chk("bp_hold_k", 64'(out_k), 64'd4);
        chk("bp_hold_m", 64'(out_m), 64'd0);
      end
      if (c == 4) begin
        in_valid = 1'b1; in_x = pend[0]; out_ready = 1'b1; #1;
        chk("bp_in_ready_return", 64'(in_ready), 64'd1);
      end
      cycle(pend.size() != 0, (pend.size() != 0) ? pend[0] : 32'd0, c >= 4, acc);
      if (acc) void'(pend.pop_front());
    end
    chk("bp_all_sent", 64'(pend.size()), 64'd0);
    chk("bp_all_out", 64'(exp_q.size()), 64'd0);

    // Reset with both stages full flushes them
    cycle(1'b1, 32'h0000_AAAA, 1'b0, acc);
    cycle(1'b1, 32'h0000_5555, 1'b0, acc);
    in_valid = 1'b0; rst = 1'b1; #1;
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    stall_prev = 1'b0;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_k", 64'(out_k), 64'd0);
    chk("rst_out_m", 64'(out_m), 64'd0);
    chk("rst_out_zero", 64'(out_zero), 64'd0);
    cycle(1'b1, 32'h0000_0003, 1'b1, acc);
    chk("rst_first_accept", 64'(acc), 64'd1);
    cycle(1'b0, 32'd0, 1'b1, acc);
    chk("rst_new_valid", 64'(out_valid), 64'd1);
    chk("rst_new_k", 64'(out_k), 64'd1);
    chk("rst_new_m", 64'(out_m), 64'h4000_0000);
    for (int i = 0; i < 4; i++) cycle(1'b0, 32'd0, 1'b1, acc);

    // Random traffic against the model
    accepted = 0;
    rx = $urandom;
    for (int c = 0; c < 40000 && accepted < 10000; c++) begin
      cycle($urandom_range(0, 3) != 0, rx, $urandom_range(0, 3) != 0, acc);
      if (acc) begin
        accepted++;
        n = int'($urandom_range(0, 7));
        if (n == 0)      rx = 32'd0;
        else if (n == 1) rx = 32'd1 << $urandom_range(0, 31);
        else             rx = $urandom >> $urandom_range(0, 31);
      end
    end
    chk("rand_accepted", 64'(accepted), 64'd10000);
    for (int i = 0; i < 6; i++) cycle(1'b0, 32'd0, 1'b1, acc);
    chk("rand_drained", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
